// File: rtl/tblink_rpc_cclock_pkg.sv
// Shared definitions for the tblink RPC multi-timer controlled-clock block:
// command codes, event code, error response byte and the event FSM state type.
package tblink_rpc_cclock_pkg;

  localparam logic [7:0] CMD_GET_TIME     = 8'd1;
  localparam logic [7:0] CMD_SET_TIMER    = 8'd2;
  localparam logic [7:0] CMD_RELEASE      = 8'd3;
  localparam logic [7:0] CMD_SET_DIVISOR  = 8'd4;
  localparam logic [7:0] CMD_HOLD         = 8'd5;
  localparam logic [7:0] CMD_CANCEL_TIMER = 8'd6;

  localparam logic [7:0] EVT_TIMER   = 8'd1;
  localparam logic [7:0] RSP_ERR_IDX = 8'hFF;

  typedef enum logic {
    EvIdle,
    EvWait
  } evt_state_e;

endpackage

// File: rtl/tblink_rpc_cclock_timer.sv
// One countdown timer channel. A value of 0 is idle; each tick decrements a
// nonzero value and the 1->0 step raises expire. A load overrides the tick, so
// a load coinciding with the final tick suppresses the expiry.
module tblink_rpc_cclock_timer
  import tblink_rpc_cclock_pkg::*;
#(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               uclock,
  input  logic               reset,
  input  logic               tick,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire,
  output logic [TIMER_W-1:0] value
);

  assign expire = tick && !load && (value == TIMER_W'(1));

  // Countdown register: load has priority over the cclock tick.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (tick && (value != '0)) begin
      value <= value - TIMER_W'(1);
    end
  end

endmodule

// File: rtl/tblink_rpc_cclock_mt.sv
// Multi-timer controlled-clock generator for the tblink RPC gateway.
// Divides uclock into cclock, counts cclock rising edges, runs N_TIMERS
// countdown timers and posts timer events to the host over a toggle handshake.
// Optional feature macro: TBLINK_RPC_CCLOCK_AUTOHOLD_EN (timer expiry holds the clock).
module tblink_rpc_cclock_mt
  import tblink_rpc_cclock_pkg::*;
#(
  parameter int unsigned N_TIMERS = 4,
  parameter int unsigned TIMER_W  = 32,
  parameter int unsigned DIV_W    = 32
) (
  input  logic        uclock,
  input  logic        reset,
  output logic        cclock,
  input  logic [7:0]  cmd_in,
  input  logic [63:0] cmd_in_params,
  input  logic        cmd_in_put_i,
  output logic        cmd_in_get_i,
  output logic [63:0] cmd_in_rsp,
  output logic [7:0]  cmd_in_rsp_sz,
  output logic [7:0]  cmd_out,
  output logic [7:0]  cmd_out_params,
  output logic        cmd_out_put_i,
  input  logic        cmd_out_get_i
);

  logic               clk_en, clk_en_next;
  logic [DIV_W-1:0]   div, div_next, div_cnt;
  logic [63:0]        count;
  logic               tick;

  logic               cmd_pend;
  logic [7:0]         cmd_idx;
  logic               idx_ok;
  logic [TIMER_W-1:0] load_val;
  logic [N_TIMERS-1:0] load, expire, pend, pend_next;
  logic [TIMER_W-1:0] tval [N_TIMERS];

  evt_state_e         evt_state;
  logic               dispatch;
  logic [7:0]         sel_idx;
  logic               unused_bits;

  // tick marks the uclock edge on which cclock goes low to high.
  assign tick = clk_en && (div_cnt == div) && !cclock;

  // Command decode: next enable/divisor and per-channel timer loads.
  always_comb begin
    cmd_pend    = cmd_in_put_i != cmd_in_get_i;
    cmd_idx     = cmd_in_params[39:32];
    idx_ok      = 32'(cmd_idx) < N_TIMERS;
    clk_en_next = clk_en;
    div_next    = div;
    load        = '0;
    load_val    = (cmd_in == CMD_SET_TIMER) ? cmd_in_params[TIMER_W-1:0] : '0;
    if (cmd_pend) begin
      case (cmd_in)
        CMD_RELEASE:     clk_en_next = 1'b1;
        CMD_HOLD:        clk_en_next = 1'b0;
        CMD_SET_DIVISOR: div_next = cmd_in_params[DIV_W-1:0];
        CMD_SET_TIMER, CMD_CANCEL_TIMER: begin
          for (int i = 0; i < N_TIMERS; i++) begin
            if (cmd_idx == 8'(i)) load[i] = 1'b1;
          end
        end
        default: ;
      endcase
    end
`ifdef TBLINK_RPC_CCLOCK_AUTOHOLD_EN
    // An expiry holds the clock in the same cycle its pending bit is set.
    if (|expire) clk_en_next = 1'b0;
`endif
  end

  // Clock divider, enable/divisor registers and the 64-bit cclock edge count.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      cclock  <= 1'b0;
      div_cnt <= '0;
      count   <= '0;
      clk_en  <= 1'b0;
      div     <= '0;
    end else begin
      clk_en <= clk_en_next;
      div    <= div_next;
      if (clk_en) begin
        if (div_cnt == div) begin
          cclock  <= ~cclock;
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        div_cnt <= '0;
      end
      if (tick) count <= count + 64'd1;
    end
  end

  // Command response: executes each pending command once and acks by toggle.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      cmd_in_get_i  <= 1'b0;
      cmd_in_rsp    <= '0;
      cmd_in_rsp_sz <= '0;
    end else if (cmd_pend) begin
      cmd_in_get_i  <= cmd_in_put_i;
      cmd_in_rsp    <= '0;
      cmd_in_rsp_sz <= '0;
      case (cmd_in)
        CMD_GET_TIME: begin
          cmd_in_rsp    <= count;
          cmd_in_rsp_sz <= 8'd8;
        end
        CMD_SET_TIMER, CMD_CANCEL_TIMER: begin
          if (!idx_ok) begin
            cmd_in_rsp    <= {56'd0, RSP_ERR_IDX};
            cmd_in_rsp_sz <= 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_TIMERS; g++) begin : g_timer
    tblink_rpc_cclock_timer #(
      .TIMER_W(TIMER_W)
    ) u_timer (
      .uclock  (uclock),
      .reset   (reset),
      .tick    (tick),
      .load    (load[g]),
      .load_val(load_val),
      .expire  (expire[g]),
      .value   (tval[g])
    );
  end

  // Lowest-index pending channel wins dispatch.
  always_comb begin
    sel_idx = '0;
    for (int i = int'(N_TIMERS) - 1; i >= 0; i--) begin
      if (pend[i]) sel_idx = 8'(i);
    end
  end

  assign dispatch = (evt_state == EvIdle) && (|pend);

  // Pending next state: a fresh expiry survives dispatch of another index;
  // a load always clears its channel.
  always_comb begin
    pend_next = pend;
    for (int i = 0; i < N_TIMERS; i++) begin
      if (dispatch && (sel_idx == 8'(i))) pend_next[i] = 1'b0;
    end
    pend_next = (pend_next | expire) & ~load;
  end

  // Pending bits register.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) pend <= '0;
    else       pend <= pend_next;
  end

  // Event FSM: post one timer event per host handshake.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      evt_state      <= EvIdle;
      cmd_out        <= '0;
      cmd_out_params <= '0;
      cmd_out_put_i  <= 1'b0;
    end else begin
      case (evt_state)
        EvIdle: begin
          if (|pend) begin
            cmd_out        <= EVT_TIMER;
            cmd_out_params <= sel_idx;
            cmd_out_put_i  <= ~cmd_out_put_i;
            evt_state      <= EvWait;
          end
        end
        EvWait: begin
          if (cmd_out_get_i == cmd_out_put_i) evt_state <= EvIdle;
        end
        default: evt_state <= EvIdle;
      endcase
    end
  end

  // Parameter bits above the fields and timer values are not otherwise consumed.
  always_comb begin
    unused_bits = ^cmd_in_params;
    for (int i = 0; i < N_TIMERS; i++) unused_bits = unused_bits ^ (^tval[i]);
  end

endmodule
